weight_stream_ctrl: RTL and testbench
=====================================

Name: weight_stream_ctrl

Overview:
- Sequencer for one neuron's weight memory in the fully connected accelerator.
- On a start pulse it reads weights 0..numWeight-1 from the weight memory and the matching activations from the input buffer, in lockstep.
- It presents each (weight, activation) pair to the downstream MAC through a valid/ready handshake, then pulses done.
- Memories have 1-cycle registered read latency and hold their output while ren=0; the controller uses that hold to stall without a skid buffer.

Parameters:
- numWeight, 30, weights (and activations) per neuron.
- addressWidth, $clog2(numWeight+1), width of memory addresses (room for the bias slot).
- dataWidth, 16, weight/activation width, signed fixed point.
- fracBits, 12, fractional bits of the fixed-point format (used only by the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to process one neuron
- busy  out  1  high while a sequence is in progress
- done  out  1  one-cycle pulse after the last beat is accepted
- w_ren  out  1  weight memory read enable
- w_radd  out  addressWidth  weight memory read address
- w_rdata  in  dataWidth  weight memory read data (valid 1 cycle after w_ren, held otherwise)
- x_ren  out  1  input buffer read enable
- x_radd  out  addressWidth  input buffer read address
- x_rdata  in  dataWidth  input buffer read data (same timing as w_rdata)
- mac_valid  out  1  beat valid to MAC
- mac_ready  in  1  MAC accepts beat
- mac_w  out  dataWidth  weight for this beat
- mac_x  out  dataWidth  activation for this beat
- mac_first  out  1  first beat of the neuron (MAC clears its accumulator)
- mac_last  out  1  last beat of the neuron

Behaviour:
- Clock is clk; reset is synchronous, active-low, on rst_n. While rst_n=0 at a rising edge: state=IDLE, address counter=0, busy=0, done=0, w_ren=x_ren=0, w_radd=x_radd=0, mac_valid=0, mac_first=0, mac_last=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, counter=0.
- In RUN, issue = !mac_valid || mac_ready. When issue=1:
  - w_ren=x_ren=1 with w_radd=x_radd=counter (combinational from counter and state); counter increments.
  - When the last address numWeight-1 is issued, go to DRAIN.
- When issue=0 (stall), w_ren=x_ren=0 and addresses hold; memory outputs hold the previous beat.
- Beat register, updated on every rising edge:
  - mac_valid <= issue ? 1 : (mac_ready ? 0 : mac_valid).
  - mac_first and mac_last are registered alongside: first when the issued address was 0, last when it was the final address. Both hold during a stall.
- mac_w=w_rdata and mac_x=x_rdata directly; they are meaningful only while mac_valid=1.
- DRAIN: no reads. When mac_valid && mac_ready && mac_last -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in RUN, DRAIN and DONE.
- Latency with mac_ready held at 1:
  - start sampled at edge k; address 0 issued in cycle k+1.
  - First mac_valid in cycle k+2; numWeight contiguous beats; last beat in cycle k+1+numWeight.
  - done in cycle k+2+numWeight; start may be accepted in the following cycle.
- start while busy=1 is ignored (no queuing).
- numWeight=1: a single beat with mac_first=mac_last=1.
- mac_ready=0 for any duration: exactly one read per accepted beat; no beat lost or duplicated.
- Reset mid-sequence aborts immediately to IDLE with outputs at their reset values; no done pulse.
- Counter never exceeds numWeight (or numWeight+1 with the optional feature); no wrap-around.

Optional Feature:
- Macro BIAS_FETCH_EN.
- Defined:
  - After address numWeight-1, one extra weight read at address numWeight (the bias slot); x_ren stays 0.
  - The extra beat has mac_x = 1<<fracBits (1.0), mac_last=1; the previous beat has mac_last=0.
  - Total beats = numWeight+1; done one cycle later than without the feature.
- Undefined: exactly numWeight beats; the counter never reaches numWeight.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles with start=1 -> all outputs 0, busy=0, no w_ren.
- Basic run, numWeight=30, mac_ready=1, start at cycle 10 -> w_radd 0..29 in cycles 11..40; mac_valid cycles 12..41; mac_first at 12, mac_last at 41; done at 42; mac_w/mac_x match memory contents at each address.
- Backpressure: mac_ready=0 during cycles 15..17 -> beat 3 (address 3) held for 4 cycles; no read issued while stalled; all 30 beats delivered in order; done at 45.
- start asserted again at cycle 20 while busy -> ignored; exactly 30 beats and a single done.
- Reset mid-run: rst_n=0 at cycle 25 -> IDLE next edge, mac_valid=0, no done; a fresh start then produces 30 beats from address 0.
- BIAS_FETCH_EN defined, fracBits=12 -> 31 beats; beat 31 has w_radd=30, mac_x=16'h1000, mac_last=1; beat 30 has mac_last=0; done at 43.

Source files
------------

// File: rtl/weight_stream_ctrl.sv
// Weight/activation fetch sequencer for one neuron: streams (w, x) beats to the MAC.
// Define BIAS_FETCH_EN to append a bias beat (weight slot numWeight, activation 1.0).
module weight_stream_ctrl #(
  parameter int unsigned numWeight    = 30,
  parameter int unsigned addressWidth = $clog2(numWeight + 1),
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned fracBits     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_rdata,
  output logic                    x_ren,
  output logic [addressWidth-1:0] x_radd,
  input  logic [dataWidth-1:0]    x_rdata,
  output logic                    mac_valid,
  input  logic                    mac_ready,
  output logic [dataWidth-1:0]    mac_w,
  output logic [dataWidth-1:0]    mac_x,
  output logic                    mac_first,
  output logic                    mac_last
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

`ifdef BIAS_FETCH_EN
  localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight);
  localparam logic [addressWidth-1:0] BiasAddr = addressWidth'(numWeight);
  localparam logic [dataWidth-1:0]    FxOne    = dataWidth'(1) << fracBits;
`else
  localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);
`endif

  logic [1:0]              state_q, state_d;
  logic [addressWidth-1:0] cnt_q, cnt_d;
  logic                    mac_valid_q, mac_valid_d;
  logic                    mac_first_q, mac_first_d;
  logic                    mac_last_q, mac_last_d;
  logic                    issue;
`ifdef BIAS_FETCH_EN
  logic                    bias_q, bias_d;
`endif

  // A new read is only allowed when the beat register is empty or being consumed,
  // because the memories hold their output and act as the stall buffer.
  always_comb begin
    issue   = (state_q == StRun) && (!mac_valid_q || mac_ready);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (issue) begin
          if (cnt_q == LastAddr) begin
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (mac_valid_q && mac_ready && mac_last_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mac_valid_d = issue ? 1'b1 : (mac_ready ? 1'b0 : mac_valid_q);
    mac_first_d = issue ? (cnt_q == '0) : mac_first_q;
    mac_last_d  = issue ? (cnt_q == LastAddr) : mac_last_q;
`ifdef BIAS_FETCH_EN
    bias_d      = issue ? (cnt_q == BiasAddr) : bias_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mac_valid_q <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
`ifdef BIAS_FETCH_EN
      bias_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_valid_q <= mac_valid_d;
      mac_first_q <= mac_first_d;
      mac_last_q  <= mac_last_d;
`ifdef BIAS_FETCH_EN
      bias_q      <= bias_d;
`endif
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    w_ren     = issue;
    w_radd    = (state_q == StRun) ? cnt_q : '0;
    x_radd    = w_radd;
    mac_valid = mac_valid_q;
    mac_first = mac_first_q;
    mac_last  = mac_last_q;
    mac_w     = w_rdata;
`ifdef BIAS_FETCH_EN
    // The bias slot has no activation; the MAC multiplies the bias by 1.0.
    x_ren     = issue && (cnt_q != BiasAddr);
    mac_x     = bias_q ? FxOne : x_rdata;
`else
    x_ren     = issue;
    mac_x     = x_rdata;
`endif
  end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Randomized scoreboard bench for weight_stream_ctrl (honours BIAS_FETCH_EN if defined).
module tb_weight_stream_ctrl;
  localparam int NW = 30;
  localparam int AW = $clog2(NW + 1);
  localparam int DW = 16;
  localparam int FB = 12;
`ifdef BIAS_FETCH_EN
  localparam int NB = NW + 1;
`else
  localparam int NB = NW;
`endif

  logic          clk, rst_n, start, busy, done;
  logic          w_ren, x_ren, mac_valid, mac_ready, mac_first, mac_last;
  logic [AW-1:0] w_radd, x_radd;
  logic [DW-1:0] w_rdata, x_rdata, mac_w, mac_x;

  weight_stream_ctrl #(
    .numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_ren(w_ren), .w_radd(w_radd), .w_rdata(w_rdata),
    .x_ren(x_ren), .x_radd(x_radd), .x_rdata(x_rdata),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_w(mac_w), .mac_x(mac_x),
    .mac_first(mac_first), .mac_last(mac_last)
  );

  typedef struct {
    logic [DW-1:0] w;
    logic [DW-1:0] x;
    logic          first;
    logic          last;
  } beat_t;

  logic [DW-1:0] w_mem [NW+1];
  logic [DW-1:0] x_mem [NW+1];
  beat_t         sb [$];
  beat_t         exp_b;
  int cyc = 0;
  int pass_cnt = 0, chk_cnt = 0;
  int reads, done_cnt, done_cyc, first_acc_cyc, last_acc_cyc;
  int ready_mode = 0;
  int stall_lo = -1, stall_hi = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memories: 1-cycle registered read, output held while ren=0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_ren) w_rdata <= w_mem[w_radd];
    if (x_ren) x_rdata <= x_mem[x_radd];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    mac_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       mac_ready = ($urandom_range(0, 99) < 60);
        2:       mac_ready = !(cyc >= stall_lo && cyc <= stall_hi);
        default: mac_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the expected beat whenever the MAC accepts one.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (w_ren) begin
          reads++;
          if (w_radd < AW'(NW)) chk("x_lockstep", {x_ren, x_radd}, {1'b1, w_radd});
          else chk("bias_x_idle", x_ren, 0);
        end
        if (mac_valid && !mac_ready) chk("no_read_in_stall", w_ren, 0);
        if (mac_valid && mac_ready) begin
          chk("beat_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mac_w", mac_w, e.w);
            chk("mac_x", mac_x, e.x);
            chk("mac_first", mac_first, e.first);
            chk("mac_last", mac_last, e.last);
            if (e.first) first_acc_cyc = cyc;
            if (e.last) last_acc_cyc = cyc;
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_after_last", cyc - last_acc_cyc, 1);
          chk("done_sb_empty", sb.size(), 0);
        end
      end
    end
  end

  task automatic load_and_expect();
    for (int i = 0; i <= NW; i++) begin
      w_mem[i] = DW'($urandom);
      x_mem[i] = DW'($urandom);
    end
    for (int i = 0; i < NB; i++) begin
      exp_b.w     = w_mem[i];
      exp_b.x     = (i >= NW) ? DW'(1 << FB) : x_mem[i];
      exp_b.first = (i == 0);
      exp_b.last  = (i == NB - 1);
      sb.push_back(exp_b);
    end
    reads    = 0;
    done_cnt = 0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for three cycles on beat 3.
  task automatic run_neuron(input int mode, input int extra_start_at);
    int sc;
    load_and_expect();
    @(posedge clk);
    #1;
    start = 1'b1;
    sc = cyc;
    ready_mode = mode;
    if (mode == 2) begin
      stall_lo = sc + 5;
      stall_hi = sc + 7;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk);
      #1;
      start = (extra_start_at > 0 && cyc == sc + extra_start_at);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", done_cnt, 1);
    chk("reads_per_beat", reads, NB);
    chk("all_beats_seen", sb.size(), 0);
    if (mode == 0) begin
      chk("first_beat_latency", first_acc_cyc - sc, 2);
      chk("done_latency", done_cyc - sc, 2 + NB);
    end else if (mode == 2) begin
      chk("first_beat_latency_bp", first_acc_cyc - sc, 2);
      chk("done_latency_bp", done_cyc - sc, 5 + NB);
    end
    ready_mode = 0;
    stall_lo = -1;
    stall_hi = -1;
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {busy, done, w_ren, x_ren, mac_valid, mac_first, mac_last}, 0);
      chk("reset_addr", {w_radd, x_radd}, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {busy, w_ren, mac_valid}, 0);

    run_neuron(0, 10);
    run_neuron(2, 10);
    for (int r = 0; r < 4; r++) run_neuron(1, 10);

    // Reset in the middle of a sequence.
    load_and_expect();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ready_mode = 1;
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_outputs", {busy, done, w_ren, mac_valid, mac_first, mac_last}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    run_neuron(0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
